// File: rtl/fir_decim_fifo.sv
// Post-FIR stage: drops the pipeline-fill transient, keeps 1 of every DECIM
// samples and buffers them in a first-word-fall-through FIFO drained by valid/ready.
module fir_decim_fifo #(
  parameter int DECIM  = 4,
  parameter int SETTLE = 10,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic          fclk,
  input  logic          reset,
  input  logic          enable,
  input  logic [31:0]   din,
  output logic [31:0]   m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          clr_ovf,
  output logic [15:0]   drop_cnt
);
  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam int PW = (DECIM < 2) ? 1 : $clog2(DECIM);
  localparam int LW = AW + 1;

  logic [SW-1:0]              settle_q, settle_d;
  logic [PW-1:0]              phase_q, phase_d;
  logic [DEPTH-1:0][31:0]     mem_q, mem_d;
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]              level_q, level_d;
  logic                       overflow_q, overflow_d;
  logic [15:0]                drop_cnt_q, drop_cnt_d;
  logic settled, kept, pop, full, push, drop;

  assign settled  = (settle_q == SW'(SETTLE));
  assign kept     = enable & settled & (phase_q == '0);
  assign m_tvalid = (level_q != '0);
  assign m_tdata  = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

  // Settle/phase restart on every enable rise so the refilled FIR transient is skipped.
  always_comb begin
    settle_d = settle_q;
    phase_d  = phase_q;
    if (!enable) begin
      settle_d = '0;
      phase_d  = '0;
    end else if (!settled) begin
      settle_d = settle_q + 1'b1;
    end else if (phase_q == PW'(DECIM - 1)) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + 1'b1;
    end
  end

  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  always_comb begin
    pop      = m_tvalid & m_tready;
    full     = (level_q == LW'(DEPTH));
    push     = kept & (~full | pop);
    drop     = kept & full & ~pop;
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q] = din;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_ovf)                    drop_cnt_d = 16'd1;
      else if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      settle_q   <= '0;
      phase_q    <= '0;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      settle_q   <= settle_d;
      phase_q    <= phase_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
endmodule

// File: tb/tb_fir_decim_fifo.sv
// Randomized bench for fir_decim_fifo against a queue-based stream model,
// plus a DECIM=1/SETTLE=0 instance for bit-exact pass-through.
module tb_fir_decim_fifo;
  localparam int DECIM = 4, SETTLE = 10, DEPTH = 8;

  logic        fclk = 1'b0, reset = 1'b1;
  logic        enable = 1'b0, m_tready = 1'b0, clr_ovf = 1'b0;
  logic [31:0] din = '0, m_tdata;
  logic        m_tvalid, overflow;
  logic [3:0]  level;
  logic [15:0] drop_cnt;

  logic        e1 = 1'b0, r1 = 1'b0, v1, o1;
  logic [31:0] d1 = '0, t1;
  logic [2:0]  l1;
  logic [15:0] dc1;

  always #5 fclk = ~fclk;

  fir_decim_fifo #(.DECIM(DECIM), .SETTLE(SETTLE), .DEPTH(DEPTH)) dut (
    .fclk(fclk), .reset(reset), .enable(enable), .din(din),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .level(level), .overflow(overflow), .clr_ovf(clr_ovf), .drop_cnt(drop_cnt));

  fir_decim_fifo #(.DECIM(1), .SETTLE(0), .DEPTH(4)) dut1 (
    .fclk(fclk), .reset(reset), .enable(e1), .din(d1),
    .m_tdata(t1), .m_tvalid(v1), .m_tready(r1),
    .level(l1), .overflow(o1), .clr_ovf(1'b0), .drop_cnt(dc1));

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h @%0t", tag, act, exp, $time);
    end
  endtask

  // Model: samples since enable rise, list of buffered samples, sticky flags.
  logic [31:0] q[$];
  int          n_en;
  bit          m_ovf;
  int          m_dc;

  task automatic model_reset();
    q.delete(); n_en = 0; m_ovf = 0; m_dc = 0;
  endtask

  task automatic model_edge();
    bit keep, pop, drop;
    keep = 0;
    if (!enable) n_en = 0;
    else begin
      keep = (n_en >= SETTLE) && ((n_en - SETTLE) % DECIM == 0);
      n_en++;
    end
    pop  = m_tready && q.size() > 0;
    drop = keep && q.size() == DEPTH && !pop;
    if (pop) void'(q.pop_front());
    if (keep && !drop) q.push_back(din);
    if (drop) begin
      m_ovf = 1;
      m_dc  = clr_ovf ? 1 : (m_dc < 65535 ? m_dc + 1 : 65535);
    end else if (clr_ovf) begin
      m_ovf = 0; m_dc = 0;
    end
  endtask

  task automatic check_all();
    chk("tvalid", 32'(m_tvalid), 32'(q.size() != 0));
    if (q.size() != 0) chk("tdata", m_tdata, q[0]);
    chk("level", 32'(level), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_dc));
  endtask

  task automatic cyc(input logic en, input logic [31:0] d, input logic rdy, input logic clr);
    enable = en; din = d; m_tready = rdy; clr_ovf = clr;
    @(posedge fclk);
    model_edge();
    #1 check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check_all();
    chk("rst_tdata", m_tdata, 32'h0);
    chk("rst_tvalid1", 32'(v1), 32'h0);
    @(negedge fclk);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    chk("rst_tdata", m_tdata, 32'h0);
    @(negedge fclk);
    reset = 1'b0;

    // Ramp with free-running consumer: 11, 15, 19, ...
    for (int k = 1; k <= 40; k++) begin
      cyc(1'b1, 32'(k), 1'b1, 1'b0);
      chk("level_le1", 32'(level <= 1), 32'h1);
    end
    // Stall the consumer: fill, then drop.
    for (int k = 41; k <= 80; k++) cyc(1'b1, 32'(k), 1'b0, 1'b0);
    // Release while enable continues, covering push+pop at full.
    for (int k = 81; k <= 90; k++) cyc(1'b1, 32'(k), 1'b1, 1'b0);
    for (int k = 91; k <= 100; k++) cyc(1'b1, 32'(k), 1'b0, 1'b0);
    // Enable gap, ramp restarts at 100: first new keep is 110.
    for (int k = 0; k < 3; k++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 100; k <= 140; k++) cyc(1'b1, 32'(k), (k > 120), 1'b0);

    // Pass-through instance: one output per cycle, bit-exact.
    e1 = 1'b1; r1 = 1'b1; d1 = 32'h8000_0000;
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("p1_v", 32'(v1), 32'h1); chk("p1_d", t1, 32'h8000_0000);
    d1 = 32'h7FFF_FFFF;
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("p2_d", t1, 32'h7FFF_FFFF); chk("p2_l", 32'(l1), 32'h1);
    d1 = 32'hFFFF_FFFF;
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("p3_d", t1, 32'hFFFF_FFFF);
    e1 = 1'b0;
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("p4_v", 32'(v1), 32'h0);

    // Random traffic: mostly-stalled consumer first, then mostly-ready.
    for (int i = 0; i < 3000; i++) begin
      logic rdy;
      rdy = (i < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
      cyc($urandom_range(0, 19) != 0, $urandom, rdy, $urandom_range(0, 29) == 0);
    end

    // Fill and overflow, pop 3 with no pushes, then reset at level 5.
    for (int k = 0; k < 60; k++) cyc(1'b1, $urandom, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd5);
    chk("pre_rst_ovf", 32'(overflow), 32'h1);
    do_reset();

    // clr_ovf alone clears flags and leaves the FIFO intact.
    for (int k = 0; k < 60; k++) cyc(1'b1, $urandom, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    chk("clr_level", 32'(level), 32'd8);
    chk("clr_ovf", 32'(overflow), 32'h0);
    for (int k = 0; k < 10; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
